// File: rtl/mmio_pkg.sv
// mmio_pkg: shared types and default address map for the MMIO I/O controller.
package mmio_pkg;

   // Bus command encoding; ILLEGAL behaves as NONE but flags bus_err.
   typedef enum logic [1:0] {
      NONE    = 2'b00,
      READ    = 2'b01,
      WRITE   = 2'b10,
      ILLEGAL = 2'b11
   } mem_cmd_t;

   // Read response FSM states.
   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } rd_state_t;

   // Default I/O address map (9-bit bus).
   localparam logic [8:0] SW_ADDR  = 9'h140;
   localparam logic [8:0] LED_ADDR = 9'h100;
   localparam logic [8:0] HEX_ADDR = 9'h101;

endpackage : mmio_pkg

// File: rtl/mmio_sync.sv
// mmio_sync: multi-bit flop-chain synchroniser for slow board inputs.
// STAGES must be at least 2.
module mmio_sync #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] chain;

   // Shift the raw input through the chain; the last stage is the safe copy.
   always_ff @(posedge clk) begin
      // NOTE: the chain is reset like any other state so a read right after
      // reset returns a known value instead of whatever the flops powered up to.
      if (reset) begin
         chain <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage sample the old value
         // of its neighbour, which is what makes this a chain and not a wire.
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule : mmio_sync

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped I/O block beside the RAM on the CPU bus.
// Holds the LED and HEX registers, exposes synchronised switches, and answers
// reads with one-cycle latency. Define MMIO_ACCESS_CNT_EN to add a saturating
// write counter readable (and clearable) at HEX_ADDR+1.
module mmio_io_ctrl #(
   parameter int                ADDR_W      = 9,
   parameter int                DATA_W      = 16,
   parameter logic [ADDR_W-1:0] SW_ADDR     = mmio_pkg::SW_ADDR,
   parameter logic [ADDR_W-1:0] LED_ADDR    = mmio_pkg::LED_ADDR,
   parameter logic [ADDR_W-1:0] HEX_ADDR    = mmio_pkg::HEX_ADDR,
   parameter int                SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        mem_cmd,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic [7:0]        sw_in,
   output logic [DATA_W-1:0] read_data,
   output logic              read_hit,
   output logic [7:0]        ledr_out,
   output logic [DATA_W-1:0] hex_value,
   output logic              bus_err
);

   import mmio_pkg::*;

   localparam int PAD_W = DATA_W - 8;

   mem_cmd_t          cmd;
   rd_state_t         state;
   logic [7:0]        sw_sync;
   logic              io_decode;
   logic [DATA_W-1:0] rd_mux;

   assign cmd = mem_cmd_t'(mem_cmd);

   mmio_sync #(
      .WIDTH  (8),
      .STAGES (SYNC_STAGES)
   ) u_sw_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sw_in),
      .q     (sw_sync)
   );

`ifdef MMIO_ACCESS_CNT_EN
   localparam logic [ADDR_W-1:0] CNT_ADDR = HEX_ADDR + {{(ADDR_W-1){1'b0}}, 1'b1};
   logic [7:0] acc_cnt;
`endif

   // Address decode and read-data selection for the I/O registers.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch
      // is inferred for addresses that fall into RAM space.
      io_decode = 1'b0;
      rd_mux    = '0;
      if (mem_addr == SW_ADDR) begin
         io_decode = 1'b1;
         rd_mux    = {{PAD_W{1'b0}}, sw_sync};
      end else if (mem_addr == LED_ADDR) begin
         io_decode = 1'b1;
         rd_mux    = {{PAD_W{1'b0}}, ledr_out};
      end else if (mem_addr == HEX_ADDR) begin
         io_decode = 1'b1;
         rd_mux    = hex_value;
      end
`ifdef MMIO_ACCESS_CNT_EN
      else if (mem_addr == CNT_ADDR) begin
         io_decode = 1'b1;
         rd_mux    = {{PAD_W{1'b0}}, acc_cnt};
      end
`endif
   end

   // CPU-writable registers and the sticky illegal-access flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         ledr_out  <= '0;
         hex_value <= '0;
         bus_err   <= 1'b0;
      end else begin
         case (cmd)
            WRITE: begin
               if (mem_addr == LED_ADDR) ledr_out  <= write_data[7:0];
               if (mem_addr == HEX_ADDR) hex_value <= write_data;
               if (mem_addr == SW_ADDR)  bus_err   <= 1'b1;
            end
            ILLEGAL: bus_err <= 1'b1;
            default: ;
         endcase
      end
   end

`ifdef MMIO_ACCESS_CNT_EN
   // Saturating count of accepted LED/HEX writes; a write to CNT_ADDR clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_cnt <= '0;
      end else if (cmd == WRITE) begin
         if (mem_addr == CNT_ADDR) begin
            acc_cnt <= '0;
         end else if ((mem_addr == LED_ADDR || mem_addr == HEX_ADDR) && acc_cnt != 8'hFF) begin
            acc_cnt <= acc_cnt + 8'd1;
         end
      end
   end
`endif

   // Read response FSM: a decoded READ loads read_data and raises read_hit next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         read_data <= '0;
         read_hit  <= 1'b0;
      end else begin
         case (state)
            IDLE, RESP: begin
               if (cmd == READ && io_decode) begin
                  state     <= RESP;
                  read_data <= rd_mux;
                  read_hit  <= 1'b1;
               end else begin
                  state     <= IDLE;
                  read_hit  <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               read_hit <= 1'b0;
            end
         endcase
      end
   end

endmodule : mmio_io_ctrl

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl: directed vector table plus multi-cycle sequences for mmio_io_ctrl.
module tb_mmio_io_ctrl;

   import mmio_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  mem_cmd;
   logic [8:0]  mem_addr;
   logic [15:0] write_data;
   logic [7:0]  sw_in;
   logic [15:0] read_data;
   logic        read_hit;
   logic [7:0]  ledr_out;
   logic [15:0] hex_value;
   logic        bus_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mmio_io_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .mem_cmd    (mem_cmd),
      .mem_addr   (mem_addr),
      .write_data (write_data),
      .sw_in      (sw_in),
      .read_data  (read_data),
      .read_hit   (read_hit),
      .ledr_out   (ledr_out),
      .hex_value  (hex_value),
      .bus_err    (bus_err)
   );

   typedef struct {
      logic [1:0]  cmd;
      logic [8:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
      logic        exp_hit;
      logic [7:0]  exp_led;
      logic [15:0] exp_hex;
      logic        exp_err;
   } vec_t;

   localparam int NVEC = 10;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // One bus cycle: drive away from the edge, clock, then settle before sampling.
   task automatic bus_cycle(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
      mem_cmd    = cmd;
      mem_addr   = addr;
      write_data = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus_cycle(NONE, 9'h000, 16'h0000);
      reset = 1'b0;
   endtask

   task automatic check_all(input string tag, input logic [15:0] rd, input logic hit,
                            input logic [7:0] led, input logic [15:0] hex, input logic err);
      check({tag, ".read_data"}, read_data, rd);
      check({tag, ".read_hit"}, {15'd0, read_hit}, {15'd0, hit});
      check({tag, ".ledr_out"}, {8'd0, ledr_out}, {8'd0, led});
      check({tag, ".hex_value"}, hex_value, hex);
      check({tag, ".bus_err"}, {15'd0, bus_err}, {15'd0, err});
   endtask

   initial begin
      // Vectors start from reset with sw_in held at 0.
      vecs[0] = '{WRITE, 9'h100, 16'hABCD, 16'h0000, 1'b0, 8'hCD, 16'h0000, 1'b0};
      vecs[1] = '{READ,  9'h100, 16'h0000, 16'h00CD, 1'b1, 8'hCD, 16'h0000, 1'b0};
      vecs[2] = '{NONE,  9'h000, 16'h0000, 16'h00CD, 1'b0, 8'hCD, 16'h0000, 1'b0};
      vecs[3] = '{WRITE, 9'h101, 16'h0BEE, 16'h00CD, 1'b0, 8'hCD, 16'h0BEE, 1'b0};
      vecs[4] = '{READ,  9'h101, 16'h0000, 16'h0BEE, 1'b1, 8'hCD, 16'h0BEE, 1'b0};
      vecs[5] = '{READ,  9'h050, 16'h0000, 16'h0BEE, 1'b0, 8'hCD, 16'h0BEE, 1'b0};
      vecs[6] = '{READ,  9'h140, 16'h0000, 16'h0000, 1'b1, 8'hCD, 16'h0BEE, 1'b0};
      vecs[7] = '{WRITE, 9'h050, 16'hFFFF, 16'h0000, 1'b0, 8'hCD, 16'h0BEE, 1'b0};
      vecs[8] = '{WRITE, 9'h100, 16'hFF12, 16'h0000, 1'b0, 8'h12, 16'h0BEE, 1'b0};
      vecs[9] = '{READ,  9'h100, 16'h0000, 16'h0012, 1'b1, 8'h12, 16'h0BEE, 1'b0};

      sw_in = 8'h00;
      do_reset();
      check_all("reset", 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0);

      for (int i = 0; i < NVEC; i++) begin
         bus_cycle(vecs[i].cmd, vecs[i].addr, vecs[i].wdata);
         check_all($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_hit,
                   vecs[i].exp_led, vecs[i].exp_hex, vecs[i].exp_err);
      end

      // Switch synchroniser latency: a READ one cycle after the change sees the old value.
      sw_in = 8'h5A;
      bus_cycle(NONE, 9'h000, 16'h0000);
      bus_cycle(READ, 9'h140, 16'h0000);
      check("sw_early.read_data", read_data, 16'h0000);
      check("sw_early.read_hit", {15'd0, read_hit}, 16'h0001);
      bus_cycle(READ, 9'h140, 16'h0000);
      check("sw_late.read_data", read_data, 16'h005A);
      check("sw_late.read_hit", {15'd0, read_hit}, 16'h0001);
      bus_cycle(NONE, 9'h000, 16'h0000);
      check("sw_hit_drop", {15'd0, read_hit}, 16'h0000);

      // Back-to-back reads keep read_hit high and stream both values.
      bus_cycle(WRITE, 9'h101, 16'h1234);
      check("b2b.hex_value", hex_value, 16'h1234);
      bus_cycle(READ, 9'h101, 16'h0000);
      check("b2b0.read_hit", {15'd0, read_hit}, 16'h0001);
      check("b2b0.read_data", read_data, 16'h1234);
      bus_cycle(READ, 9'h140, 16'h0000);
      check("b2b1.read_hit", {15'd0, read_hit}, 16'h0001);
      check("b2b1.read_data", read_data, 16'h005A);
      bus_cycle(NONE, 9'h000, 16'h0000);
      check("b2b_end.read_hit", {15'd0, read_hit}, 16'h0000);

      // Write to the read-only switch address: sticky error, no register change.
      bus_cycle(WRITE, 9'h140, 16'h00FF);
      check_all("sw_write", 16'h005A, 1'b0, 8'h12, 16'h1234, 1'b1);
      bus_cycle(WRITE, 9'h100, 16'h0077);
      bus_cycle(READ, 9'h100, 16'h0000);
      check_all("err_sticky", 16'h0077, 1'b1, 8'h77, 16'h1234, 1'b1);

      // Reset during RESP discards the response; sync flops restart at 0.
      bus_cycle(READ, 9'h140, 16'h0000);
      check("resp_before_reset.read_hit", {15'd0, read_hit}, 16'h0001);
      do_reset();
      check_all("reset_in_resp", 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0);
      bus_cycle(READ, 9'h140, 16'h0000);
      check("sync_cleared.read_data", read_data, 16'h0000);

      // Illegal command acts as NONE and sets the sticky error.
      bus_cycle(ILLEGAL, 9'h100, 16'h00AA);
      check_all("illegal", 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1);
      bus_cycle(WRITE, 9'h101, 16'h5555);
      check("illegal_sticky.bus_err", {15'd0, bus_err}, 16'h0001);
      do_reset();
      check("err_cleared.bus_err", {15'd0, bus_err}, 16'h0000);

`ifdef MMIO_ACCESS_CNT_EN
      // Write counter saturates at FF and clears on a write to HEX_ADDR+1.
      for (int i = 0; i < 300; i++) bus_cycle(WRITE, 9'h100, 16'(i));
      bus_cycle(READ, 9'h102, 16'h0000);
      check("cnt_sat.read_data", read_data, 16'h00FF);
      check("cnt_sat.read_hit", {15'd0, read_hit}, 16'h0001);
      bus_cycle(WRITE, 9'h102, 16'h0000);
      bus_cycle(READ, 9'h102, 16'h0000);
      check("cnt_clr.read_data", read_data, 16'h0000);
      check("cnt_clr.bus_err", {15'd0, bus_err}, 16'h0000);
`else
      // Without the counter, HEX_ADDR+1 is RAM space and never hits.
      bus_cycle(READ, 9'h102, 16'h0000);
      check("no_cnt.read_hit", {15'd0, read_hit}, 16'h0000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mmio_io_ctrl
